// File: rtl/pipe_pal_ingress.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pipe_pal_ingress : address-tagging valid/ready ingress FIFO     |
// | Revision 1.0                                                    |
// +-----------------------------------------------------------------+
module pipe_pal_ingress #(
  parameter int W_DATA = 32,
  parameter int W_ADDR = 16,
  parameter int DEPTH  = 4
) (
  input  logic                      i_clk,
  input  logic                      resetn,
  input  logic                      i_flush,
  input  logic [W_ADDR-1:0]         i_base_addr,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [W_DATA-1:0]         i_data,
  input  logic                      i_last,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [W_DATA-1:0]         o_data,
  output logic [W_ADDR-1:0]         o_addr,
  output logic                      o_last,
  output logic [$clog2(DEPTH):0]    o_count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_ENT_W = W_DATA + W_ADDR + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [W_ADDR-1:0]    r_last_addr;
  logic [W_ADDR-1:0]    w_tag;
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic [c_ENT_W-1:0]   r_mem [DEPTH];
  logic [c_ENT_W-1:0]   w_head;
  logic                 w_push;
  logic                 w_pop;

  // Handshakes decode only from the registered count.
  assign o_ready = (r_count != c_FULL);
  assign o_valid = (r_count != '0);
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_ready;
  assign o_count = r_count;

  always_comb begin
    w_state_nxt = r_state;
    w_tag       = i_base_addr;
    case (r_state)
      ST_IDLE: begin
        w_tag = i_base_addr;
        if (w_push && !i_last) w_state_nxt = ST_FRAME;
      end
      ST_FRAME: begin
        w_tag = r_last_addr + 1'b1;
        if (w_push && i_last) w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_last_addr <= '0;
    end else if (i_flush) begin
      r_state     <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_last_addr <= w_tag;
    end
  end

  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= {i_data, w_tag, i_last};
  end

  assign w_head = r_mem[r_rd_ptr];
  assign {o_data, o_addr, o_last} = w_head;

endmodule
`default_nettype wire

// File: tb/tb_pipe_pal_ingress.sv
`default_nettype none
// Testbench for pipe_pal_ingress: directed frame scenarios plus a randomized
// phase, all compared against a queue-based reference model.
module tb_pipe_pal_ingress;

  localparam int W_DATA = 32;
  localparam int W_ADDR = 16;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              flush = 1'b0;
  logic [W_ADDR-1:0] base = '0;
  logic              in_valid = 1'b0;
  logic              out_ready;
  logic [W_DATA-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              ds_ready = 1'b0;
  logic [W_DATA-1:0] out_data;
  logic [W_ADDR-1:0] out_addr;
  logic              out_last;
  logic [$clog2(DEPTH):0] out_count;

  always #5 clk = ~clk;

  pipe_pal_ingress #(.W_DATA(W_DATA), .W_ADDR(W_ADDR), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .resetn(resetn), .i_flush(flush), .i_base_addr(base),
    .i_valid(in_valid), .o_ready(out_ready), .i_data(in_data), .i_last(in_last),
    .o_valid(out_valid), .i_ready(ds_ready), .o_data(out_data), .o_addr(out_addr),
    .o_last(out_last), .o_count(out_count)
  );

  typedef struct packed {
    logic [W_DATA-1:0] d;
    logic [W_ADDR-1:0] a;
    logic              l;
  } ent_t;

  ent_t              q[$];
  bit                in_frame = 1'b0;
  logic [W_ADDR-1:0] next_addr = '0;
  bit                acc;
  int                checks = 0;
  int                errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    check_eq("o_valid", out_valid, q.size() != 0);
    check_eq("o_ready", out_ready, q.size() != DEPTH);
    check_eq("o_count", out_count, q.size());
    if (q.size() != 0) begin
      check_eq("o_data", out_data, q[0].d);
      check_eq("o_addr", out_addr, q[0].a);
      check_eq("o_last", out_last, q[0].l);
    end
  endtask

  task automatic model_clear();
    q.delete();
    in_frame = 1'b0;
  endtask

  // One clock: check at the falling edge, advance the model on the rising edge.
  task automatic cycle();
    bit   do_push, do_pop;
    ent_t e;
    @(negedge clk);
    model_check();
    @(posedge clk);
    acc = 1'b0;
    if (flush) begin
      model_clear();
    end else begin
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = (q.size() > 0) && ds_ready;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.d = in_data;
        e.a = in_frame ? next_addr : base;
        e.l = in_last;
        q.push_back(e);
        next_addr = e.a + 1'b1;
        in_frame  = !in_last;
        acc = 1'b1;
      end
    end
    #1;
  endtask

  task automatic push_word(input logic [W_DATA-1:0] d, input bit l, input logic [W_ADDR-1:0] b);
    in_valid = 1'b1; in_data = d; in_last = l; base = b;
    acc = 1'b0;
    for (int n = 0; n < 100 && !acc; n++) cycle();
    if (!acc) check_eq("push_timeout", 0, 1);
    in_valid = 1'b0;
    base = W_ADDR'($urandom);
  endtask

  // Push with the consumer draining; the new word becomes the head right away.
  task automatic push_expect(input logic [W_DATA-1:0] d, input bit l, input logic [W_ADDR-1:0] b,
                             input logic [W_ADDR-1:0] exp_addr);
    push_word(d, l, b);
    check_eq("tag_valid", out_valid, 1);
    check_eq("tag_addr", out_addr, exp_addr);
    check_eq("tag_last", out_last, l);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #2;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_ready", out_ready, 1);
    check_eq("rst_count", out_count, 0);
    #10 resetn = 1'b1;
    @(posedge clk); #1;

    // Single 3-word frame, streaming out at one word per cycle.
    ds_ready = 1'b1;
    push_expect(32'hA0, 1'b0, 16'h0100, 16'h0100);
    push_expect(32'hA1, 1'b0, W_ADDR'($urandom), 16'h0101);
    push_expect(32'hA2, 1'b1, W_ADDR'($urandom), 16'h0102);
    check_eq("steady_count", out_count, 1);
    idle(3);

    // Fill with the consumer stalled; fifth word must wait.
    ds_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(32'hB0 + i, i == 4, 16'h0200);
    check_eq("full_ready", out_ready, 0);
    check_eq("full_count", out_count, 4);
    in_valid = 1'b1; in_data = 32'hB4; in_last = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check_eq("held_fifth", acc, 0);
    ds_ready = 1'b1;
    for (int n = 0; n < 20 && !acc; n++) cycle();
    check_eq("fifth_accepted", acc, 1);
    idle(8);
    check_eq("drained", out_count, 0);

    // Back-to-back frames, then an address wrap.
    push_expect(32'hC0, 1'b0, 16'h0010, 16'h0010);
    push_expect(32'hC1, 1'b1, W_ADDR'($urandom), 16'h0011);
    push_expect(32'hC2, 1'b1, 16'h8000, 16'h8000);
    push_expect(32'hD0, 1'b0, 16'hFFFE, 16'hFFFE);
    push_expect(32'hD1, 1'b0, W_ADDR'($urandom), 16'hFFFF);
    push_expect(32'hD2, 1'b0, W_ADDR'($urandom), 16'h0000);
    push_expect(32'hD3, 1'b1, W_ADDR'($urandom), 16'h0001);
    idle(3);

    // Simultaneous push and pop holding occupancy at 2.
    ds_ready = 1'b0;
    push_word(32'hE0, 1'b0, 16'h0300);
    push_word(32'hE1, 1'b0, 16'h0300);
    ds_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = $urandom; in_last = (i == 9);
      cycle();
      check_eq("pp_accept", acc, 1);
      check_eq("pp_count", out_count, 2);
    end
    idle(4);

    // Flush mid-frame discards buffered words and restarts addressing.
    ds_ready = 1'b0;
    push_word(32'hF0, 1'b0, 16'h1234);
    push_word(32'hF1, 1'b0, 16'h1234);
    flush = 1'b1; in_valid = 1'b1; ds_ready = 1'b1; in_data = 32'hF2;
    cycle();
    flush = 1'b0; in_valid = 1'b0; ds_ready = 1'b0;
    check_eq("flush_valid", out_valid, 0);
    check_eq("flush_count", out_count, 0);
    check_eq("flush_ready", out_ready, 1);
    push_word(32'hF3, 1'b0, 16'h0ABC);
    check_eq("flush_newaddr", out_addr, 16'h0ABC);
    idle(1);

    // Same case with a short asynchronous reset pulse.
    push_word(32'hF4, 1'b0, W_ADDR'($urandom));
    #1 resetn = 1'b0;
    #1;
    check_eq("areset_valid", out_valid, 0);
    check_eq("areset_count", out_count, 0);
    check_eq("areset_ready", out_ready, 1);
    resetn = 1'b1;
    model_clear();
    push_word(32'hF5, 1'b0, 16'h0DEF);
    check_eq("reset_newaddr", out_addr, 16'h0DEF);
    idle(2);

    // Randomized traffic; inputs held while a word waits for room.
    for (int i = 0; i < 600; i++) begin
      if (!(in_valid && !acc)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = $urandom;
        in_last  = ($urandom_range(0, 3) == 0);
      end
      base     = W_ADDR'($urandom_range(0, 3) == 0 ? 16'hFFFF : $urandom);
      ds_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 49) == 0);
      cycle();
      if (flush) acc = 1'b0;
    end
    flush = 1'b0;
    ds_ready = 1'b1;
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_pal_ingress.md
# pipe_pal_ingress

Ingress buffer for the `pipe_pal` datapath. It accepts `W_DATA`-bit words on a valid/ready stream and tags each word with a `W_ADDR`-bit address generated by a per-frame counter. Tagged words are held in a `DEPTH`-entry FIFO and presented downstream on a second valid/ready stream. It decouples producer stalls from `pipe_pal` and registers every output.

## Interface

Parameters:
- `W_DATA`, default 32: data word width.
- `W_ADDR`, default 16: address tag width.
- `DEPTH`, default 4: FIFO entries; must be a power of 2 and ≥2.

Ports:
- `i_clk`  in  1  clock; all logic on the rising edge.
- `resetn`  in  1  reset; asynchronous, active-low.
- `i_flush`  in  1  synchronous clear of FIFO and frame state.
- `i_base_addr`  in  `W_ADDR`  start address, sampled on the first word of each frame.
- `i_valid`  in  1  upstream word valid.
- `o_ready`  out  1  upstream may transfer.
- `i_data`  in  `W_DATA`  upstream word.
- `i_last`  in  1  word is the last of its frame.
- `o_valid`  out  1  downstream word valid.
- `i_ready`  in  1  downstream accepts.
- `o_data`  out  `W_DATA`  head word.
- `o_addr`  out  `W_ADDR`  head address tag.
- `o_last`  out  1  head word ends its frame.
- `o_count`  out  `clog2(DEPTH)+1`  current occupancy.

## Operation

- Push happens when `i_valid && o_ready`. Pop happens when `o_valid && i_ready`.
- `o_ready = (count != DEPTH)`. It is decoded from a registered count and has no combinational dependence on `i_ready` or `i_valid`.
- `o_valid = (count != 0)`. `o_data`, `o_addr` and `o_last` are driven from the head entry.
- Outputs are undefined-but-stable when `o_valid=0`; the bench must not check them.
- Address FSM:
  - `IDLE`: the next pushed word gets `addr = i_base_addr`. A push without `i_last` moves to `FRAME`. A push with `i_last` stays in `IDLE`.
  - `FRAME`: the next pushed word gets `addr = last_addr + 1`, modulo `2^W_ADDR` (wraps from `all-ones` to 0). A push with `i_last` moves to `IDLE`.
  - No push means no state or address change.
- Simultaneous push and pop:
  - Count is unchanged, both pointers advance.
  - Legal at any non-full occupancy.
  - At full, no push occurs because `o_ready=0`.
- Pointers are `clog2(DEPTH)` bits and wrap naturally. Full and empty are taken from the count, not from pointer compare.
- `i_flush=1` at an edge:
  - count, pointers ← 0; FSM ← `IDLE`.
  - Any push or pop in that cycle is discarded.
  - `o_valid` = 0 and `o_ready` = 1 from the next cycle.
- `resetn=0`:
  - Immediately `o_valid=0`, `o_count=0`, `o_ready=1`, FSM `IDLE`, pointers 0.
  - Storage contents are not reset.
- Reset or flush mid-frame aborts the frame. The next word starts a new frame at `i_base_addr`.

## Timing

- Latency: a word pushed at edge N is visible (`o_valid=1`) after edge N. There is no same-cycle bypass, so the minimum throughput latency is 1 cycle.
- Throughput: 1 word per cycle sustained when `i_ready=1` continuously, with occupancy 1 in steady state.
- `o_ready` deasserts the cycle after the push that fills the FIFO. It reasserts the cycle after the first pop from full.
- `i_base_addr` is sampled only in the cycle of a push in `IDLE`. It may change at any other time.
- Upstream must hold `i_data`, `i_last` and `i_valid` stable while `o_ready=0`. This is not checked by the block.
- Asynchronous reset assertion affects outputs immediately. Deassertion is synchronized externally.

## Test plan

- Reset, then frame of 3 words (`i_base_addr=16'h0100`, `i_last` on word 3), `i_ready=1` → outputs addr `0100`, `0101`, `0102`, `o_last` on the third, each 1 cycle after its push.
- `i_ready=0`, push 5 words with `DEPTH=4` → `o_ready=0` after the 4th push, `o_count=4`, 5th word held. Then `i_ready=1` → all 5 delivered in order with no loss or duplicates.
- Back-to-back frames: frame A base `0x0010` (2 words), frame B base `0x8000` (1 word, `i_last`) → tags `0010`, `0011`, `8000`; B's `o_last=1`.
- Wrap: base `16'hFFFE`, 4-word frame → tags `FFFE`, `FFFF`, `0000`, `0001`.
- Simultaneous push and pop at `o_count=2` for 10 cycles → `o_count` stays 2, order preserved.
- Mid-frame `i_flush` after 2 of 4 words with 2 buffered → next cycle `o_valid=0`, `o_count=0`. A new word gets `i_base_addr`. Repeat the same case using `resetn` pulsed low for 1 ns, with the same result.
